// File: rtl/multicycle_control_unit_if.sv
// Instruction-field, ALU-flag, memory-handshake and control-output bundle for
// multicycle_control_unit; the slave modport is the control unit's side.
interface multicycle_control_unit_if #(
   parameter int unsigned ALUCTRL_W = 4
);
   logic [6:0]           i_OpCode;
   logic [2:0]           i_funct3;
   logic                 i_funct7_5;
   logic                 i_Zero;
   logic                 i_Lt;
   logic                 i_Ltu;
   logic                 i_MemReady;
   logic                 o_MemReq;
   logic                 o_PCWrite;
   logic                 o_IRWrite;
   logic                 o_MemWrite;
   logic                 o_RegWrite;
   logic                 o_AdrSrc;
   logic [1:0]           o_ResultSrc;
   logic [1:0]           o_ALUSrcA;
   logic [1:0]           o_ALUSrcB;
   logic [2:0]           o_ImmSrc;
   logic [ALUCTRL_W-1:0] o_ALUControl;
   logic [3:0]           o_State;
   logic                 o_InstrDone;
   logic                 o_Trap;

   modport master (
      output i_OpCode, i_funct3, i_funct7_5, i_Zero, i_Lt, i_Ltu, i_MemReady,
      input  o_MemReq, o_PCWrite, o_IRWrite, o_MemWrite, o_RegWrite, o_AdrSrc,
             o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc, o_ALUControl, o_State,
             o_InstrDone, o_Trap
   );

   modport slave (
      input  i_OpCode, i_funct3, i_funct7_5, i_Zero, i_Lt, i_Ltu, i_MemReady,
      output o_MemReq, o_PCWrite, o_IRWrite, o_MemWrite, o_RegWrite, o_AdrSrc,
             o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc, o_ALUControl, o_State,
             o_InstrDone, o_Trap
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM sequencing fetch, decode, execute, memory and writeback.
// Define CTRL_TRAP_EN to add illegal-opcode and memory-wait-timeout traps.
module multicycle_control_unit #(
   parameter int unsigned ALUCTRL_W = 4,
   parameter int unsigned TIMEOUT_W = 8
) (
   input logic                      i_Clk,
   input logic                      i_Reset_n,
   multicycle_control_unit_if.slave bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
      S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_EXECI   = 4'd7,
      S_ALUWB    = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR    = 4'd11,
      S_LUI      = 4'd12, S_AUIPC  = 4'd13, S_TRAP   = 4'd14
   } state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011, OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0), ALU_SUB  = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2), ALU_OR   = ALUCTRL_W'(3);
   localparam logic [ALUCTRL_W-1:0] ALU_XOR = ALUCTRL_W'(4), ALU_SLT  = ALUCTRL_W'(5);
   localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6), ALU_SLL = ALUCTRL_W'(7);
   localparam logic [ALUCTRL_W-1:0] ALU_SRL = ALUCTRL_W'(8), ALU_SRA  = ALUCTRL_W'(9);

   if (ALUCTRL_W < 4 || TIMEOUT_W < 1) begin : g_bad_param
      $error("multicycle_control_unit: ALUCTRL_W must be >= 4 and TIMEOUT_W >= 1");
   end

   state_e state_q, state_d;
   logic   done_q, done_d;

   logic                 mem_req, pc_write, ir_write, mem_write, reg_write, adr_src, trap;
   logic [1:0]           result_src, alu_src_a, alu_src_b;
   logic [2:0]           imm_src;
   logic [ALUCTRL_W-1:0] alu_ctrl;
   logic                 taken;

`ifdef CTRL_TRAP_EN
   localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
   logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                 mem_wait;
`endif

   function automatic logic [ALUCTRL_W-1:0] alu_decode(input logic is_r,
                                                       input logic [2:0] f3,
                                                       input logic f7_5);
      case (f3)
         3'b000:  return (is_r && f7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= S_FETCH;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

`ifdef CTRL_TRAP_EN
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) wait_cnt_q <= '0;
      else            wait_cnt_q <= wait_cnt_d;
   end
`endif

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      trap       = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;

      case (bus.i_funct3)
         3'b000:  taken = bus.i_Zero;
         3'b001:  taken = !bus.i_Zero;
         3'b100:  taken = bus.i_Lt;
         3'b101:  taken = !bus.i_Lt;
         3'b110:  taken = bus.i_Ltu;
         3'b111:  taken = !bus.i_Ltu;
         default: taken = 1'b0;
      endcase

      unique case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (bus.i_MemReady) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (bus.i_OpCode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
`ifdef CTRL_TRAP_EN
               default:           state_d = S_TRAP;
`else
               default:           state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (bus.i_OpCode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.i_MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (bus.i_MemReady) state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_ctrl  = alu_decode(1'b1, bus.i_funct3, bus.i_funct7_5);
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_ctrl  = alu_decode(1'b0, bus.i_funct3, bus.i_funct7_5);
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_ctrl  = ALU_SUB;
            pc_write  = taken;
            state_d   = S_FETCH;
         end
         // JAL jumps to the target computed in DECODE while writing the old PC+4
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            state_d   = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            state_d   = S_ALUWB;
         end
`ifdef CTRL_TRAP_EN
         S_TRAP: begin
            trap    = 1'b1;
            state_d = S_TRAP;
         end
`endif
         default: state_d = S_FETCH;
      endcase

`ifdef CTRL_TRAP_EN
      // Consecutive ready-low cycles in any memory-wait state; the last one traps.
      mem_wait   = (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE) &&
                   !bus.i_MemReady;
      wait_cnt_d = '0;
      if (mem_wait) begin
         if (wait_cnt_q == WAIT_LAST) state_d = S_TRAP;
         else                         wait_cnt_d = wait_cnt_q + 1'b1;
      end
`endif

      done_d = (state_d == S_FETCH) && (state_q != S_FETCH);

      case (bus.i_OpCode)
         OP_STORE:         imm_src = 3'd1;
         OP_BR:            imm_src = 3'd2;
         OP_JAL:           imm_src = 3'd3;
         OP_LUI, OP_AUIPC: imm_src = 3'd4;
         default:          imm_src = 3'd0;
      endcase
   end

   // Outputs are forced low for as long as reset is held, not just at the edge.
   always_comb begin
      bus.o_MemReq     = i_Reset_n & mem_req;
      bus.o_PCWrite    = i_Reset_n & pc_write;
      bus.o_IRWrite    = i_Reset_n & ir_write;
      bus.o_MemWrite   = i_Reset_n & mem_write;
      bus.o_RegWrite   = i_Reset_n & reg_write;
      bus.o_AdrSrc     = i_Reset_n & adr_src;
      bus.o_InstrDone  = i_Reset_n & done_q;
      bus.o_Trap       = i_Reset_n & trap;
      bus.o_ResultSrc  = i_Reset_n ? result_src : '0;
      bus.o_ALUSrcA    = i_Reset_n ? alu_src_a : '0;
      bus.o_ALUSrcB    = i_Reset_n ? alu_src_b : '0;
      bus.o_ImmSrc     = i_Reset_n ? imm_src : '0;
      bus.o_ALUControl = i_Reset_n ? alu_ctrl : '0;
      bus.o_State      = i_Reset_n ? state_q : S_FETCH;
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction-stream bench for multicycle_control_unit: each instruction's
// phase sequence and enable counts are predicted from its class and memory stalls.
`timescale 1ns/1ps
module tb_multicycle_control_unit;
   localparam int unsigned ALUCTRL_W = 4;
   localparam int unsigned TIMEOUT_W = 3;

   localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011, OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic        clk;
   logic        rst_n;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [6:0]  op_tab [11];

   multicycle_control_unit_if #(.ALUCTRL_W(ALUCTRL_W)) ifc ();

   multicycle_control_unit #(
      .ALUCTRL_W(ALUCTRL_W),
      .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .bus       (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {7'd0, ifc.o_MemReq, ifc.o_PCWrite, ifc.o_IRWrite, ifc.o_MemWrite,
              ifc.o_RegWrite, ifc.o_AdrSrc, ifc.o_ResultSrc, ifc.o_ALUSrcA, ifc.o_ALUSrcB,
              ifc.o_ImmSrc, ifc.o_ALUControl, ifc.o_State, ifc.o_InstrDone, ifc.o_Trap};
   endfunction

   function automatic logic [3:0] alu_ref(input bit is_r, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
         3'd1:    return 4'd7;
         3'd2:    return 4'd5;
         3'd3:    return 4'd6;
         3'd4:    return 4'd4;
         3'd5:    return f7 ? 4'd9 : 4'd8;
         3'd6:    return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic logic [2:0] imm_ref(input logic [6:0] op);
      if (op == OP_STORE) return 3'd1;
      if (op == OP_BR) return 3'd2;
      if (op == OP_JAL) return 3'd3;
      if (op == OP_LUI || op == OP_AUIPC) return 3'd4;
      return 3'd0;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      ifc.i_MemReady = 1'b0;
      @(negedge clk);
      #1 check("rst_outputs_zero", all_outs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input logic [3:0] s, input string tag);
      bit hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         if (ifc.o_State == s) hit = 1'b1;
      end
      check(tag, 32'(hit), 32'd1);
   endtask

   // Runs one instruction from FETCH until the next FETCH (or TRAP) and compares
   // the observed phase path and per-instruction enable counts with the model.
   task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z, input logic lt, input logic ltu,
                            input int s0, input int s1);
      int  exp_path[$];
      int  obs_path[$];
      bit  is_ld, is_st, is_r, is_i, is_br, is_jal, is_jalr, is_lui, is_auipc, legal, tk;
      bit  trap_exp, left_fetch, finished;
      int  e_reg, e_pc, e_mw, e_req;
      int  o_reg, o_pc, o_ir, o_mw, o_req, o_trap, alu_err, path_err, stall_left, idx, es;
      logic       done_seen;
      logic [3:0] st, e_alu;

      ifc.i_OpCode = op;  ifc.i_funct3 = f3;  ifc.i_funct7_5 = f7;
      ifc.i_Zero = z;     ifc.i_Lt = lt;      ifc.i_Ltu = ltu;
      #1 check({tag, "_immsrc"}, 32'(ifc.o_ImmSrc), 32'(imm_ref(op)));

      is_ld = (op == OP_LOAD);  is_st = (op == OP_STORE); is_r = (op == OP_R);
      is_i = (op == OP_I);      is_br = (op == OP_BR);    is_jal = (op == OP_JAL);
      is_jalr = (op == OP_JALR); is_lui = (op == OP_LUI); is_auipc = (op == OP_AUIPC);
      legal = is_ld | is_st | is_r | is_i | is_br | is_jal | is_jalr | is_lui | is_auipc;
`ifdef CTRL_TRAP_EN
      trap_exp = !legal;
`else
      trap_exp = 1'b0;
`endif
      case (f3)
         3'b000:  tk = z;
         3'b001:  tk = !z;
         3'b100:  tk = lt;
         3'b101:  tk = !lt;
         3'b110:  tk = ltu;
         3'b111:  tk = !ltu;
         default: tk = 1'b0;
      endcase

      for (int i = 0; i <= s0; i++) exp_path.push_back(0);
      exp_path.push_back(1);
      if (is_ld) begin
         exp_path.push_back(2);
         for (int i = 0; i <= s1; i++) exp_path.push_back(3);
         exp_path.push_back(4);
      end
      if (is_st) begin
         exp_path.push_back(2);
         for (int i = 0; i <= s1; i++) exp_path.push_back(5);
      end
      if (is_r)     begin exp_path.push_back(6);  exp_path.push_back(8); end
      if (is_i)     begin exp_path.push_back(7);  exp_path.push_back(8); end
      if (is_br)    exp_path.push_back(9);
      if (is_jal)   exp_path.push_back(10);
      if (is_jalr)  exp_path.push_back(11);
      if (is_lui)   begin exp_path.push_back(12); exp_path.push_back(8); end
      if (is_auipc) begin exp_path.push_back(13); exp_path.push_back(8); end
      if (trap_exp) exp_path.push_back(14);

      e_reg = (is_r | is_i | is_ld | is_lui | is_auipc | is_jal | is_jalr) ? 1 : 0;
      e_pc  = 1 + ((is_br && tk) ? 1 : 0) + ((is_jal | is_jalr) ? 1 : 0);
      e_mw  = is_st ? s1 + 1 : 0;
      e_req = s0 + 1 + ((is_ld | is_st) ? s1 + 1 : 0);

      o_reg = 0; o_pc = 0; o_ir = 0; o_mw = 0; o_req = 0; o_trap = 0; alu_err = 0;
      stall_left = s0; left_fetch = 1'b0; finished = 1'b0; done_seen = 1'b0;
      for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
         @(negedge clk);
         st = ifc.o_State;
         if (left_fetch && st == 4'd0) begin
            done_seen = ifc.o_InstrDone;
            ifc.i_MemReady = 1'b0;
            finished = 1'b1;
         end else begin
            if (st != 4'd0) left_fetch = 1'b1;
            if (ifc.o_MemReq) begin
               if (stall_left > 0) begin
                  ifc.i_MemReady = 1'b0;
                  stall_left--;
               end else begin
                  ifc.i_MemReady = 1'b1;
                  stall_left = s1;
               end
            end else begin
               ifc.i_MemReady = 1'($urandom_range(0, 1));
            end
            #1;
            idx = obs_path.size();
            obs_path.push_back(int'(st));
            o_reg += int'(ifc.o_RegWrite);  o_pc  += int'(ifc.o_PCWrite);
            o_ir  += int'(ifc.o_IRWrite);   o_mw  += int'(ifc.o_MemWrite);
            o_req += int'(ifc.o_MemReq);    o_trap += int'(ifc.o_Trap);
            if (idx < exp_path.size()) begin
               es = exp_path[idx];
               e_alu = 4'hF;
               if (es == 0 || es == 1 || es == 2 || (es >= 10 && es <= 13)) e_alu = 4'd0;
               if (es == 6) e_alu = alu_ref(1'b1, f3, f7);
               if (es == 7) e_alu = alu_ref(1'b0, f3, f7);
               if (es == 9) e_alu = 4'd1;
               if (e_alu != 4'hF && ifc.o_ALUControl !== e_alu) alu_err++;
            end
            if (st == 4'd14) finished = 1'b1;
         end
      end

      check({tag, "_finished"}, 32'(finished), 32'd1);
      check({tag, "_path_len"}, 32'(obs_path.size()), 32'(exp_path.size()));
      path_err = 0;
      for (int i = 0; i < obs_path.size() && i < exp_path.size(); i++)
         if (obs_path[i] != exp_path[i]) path_err++;
      check({tag, "_path_diff"}, 32'(path_err), 32'd0);
      check({tag, "_regwrite"}, 32'(o_reg), 32'(e_reg));
      check({tag, "_pcwrite"}, 32'(o_pc), 32'(e_pc));
      check({tag, "_irwrite"}, 32'(o_ir), 32'd1);
      check({tag, "_memwrite"}, 32'(o_mw), 32'(e_mw));
      check({tag, "_memreq"}, 32'(o_req), 32'(e_req));
      check({tag, "_alu_err"}, 32'(alu_err), 32'd0);
      check({tag, "_trap"}, 32'(o_trap), trap_exp ? 32'd1 : 32'd0);
      if (!trap_exp) check({tag, "_instrdone"}, 32'(done_seen), 32'd1);
   endtask

   initial begin
      int n_ops;
      int n_fetch;
      bit hit;

      op_tab[0] = OP_LOAD; op_tab[1] = OP_STORE; op_tab[2] = OP_R;   op_tab[3] = OP_I;
      op_tab[4] = OP_BR;   op_tab[5] = OP_JAL;   op_tab[6] = OP_JALR; op_tab[7] = OP_LUI;
      op_tab[8] = OP_AUIPC; op_tab[9] = 7'h7F;   op_tab[10] = 7'h00;
`ifdef CTRL_TRAP_EN
      n_ops = 9;
`else
      n_ops = 11;
`endif

      ifc.i_OpCode = OP_BR; ifc.i_funct3 = 3'b000; ifc.i_funct7_5 = 1'b0;
      ifc.i_Zero = 1'b1; ifc.i_Lt = 1'b0; ifc.i_Ltu = 1'b0; ifc.i_MemReady = 1'b1;
      do_reset();
      #1 check("release_memreq", 32'(ifc.o_MemReq), 32'd1);
      check("release_state", 32'(ifc.o_State), 32'd0);

      run_instr("add_x3", OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr("sub", OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr("srai", OP_I, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr("lw_wait3", OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
      run_instr("sw", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr("blt_taken", OP_BR, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      run_instr("blt_not", OP_BR, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr("bgeu_taken", OP_BR, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr("br_f3_010", OP_BR, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
      run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);

      for (int k = 0; k < 40; k++) begin
         int unsigned sel;
         sel = $urandom_range(0, n_ops - 1);
         run_instr("rnd", op_tab[sel], 3'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
      end

      ifc.i_OpCode = OP_STORE;
      ifc.i_MemReady = 1'b1;
      wait_state(4'd5, "reach_memwrite");
      ifc.i_MemReady = 1'b0;
      #1 check("memwrite_before_rst", 32'(ifc.o_MemWrite), 32'd1);
      #1 rst_n = 1'b0;
      #1 check("rst_mid_memwrite", 32'(ifc.o_MemWrite), 32'd0);
      check("rst_mid_outputs", all_outs(), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("mid_release_memreq", 32'(ifc.o_MemReq), 32'd1);
      check("mid_release_state", 32'(ifc.o_State), 32'd0);

      run_instr("illegal_7f", 7'h7F, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef CTRL_TRAP_EN
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ifc.i_MemReady = 1'($urandom_range(0, 1));
         #1 check("trap_hold", {ifc.o_Trap, ifc.o_State, ifc.o_PCWrite, ifc.o_RegWrite,
                                ifc.o_MemWrite, ifc.o_IRWrite, ifc.o_MemReq},
                  {1'b1, 4'd14, 5'd0});
      end
      ifc.i_OpCode = OP_R;
      do_reset();
      n_fetch = 0;
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         #1;
         if (ifc.o_State == 4'd14) hit = 1'b1;
         else if (ifc.o_State == 4'd0) n_fetch++;
         if (!hit) @(negedge clk);
      end
      check("timeout_reached", 32'(hit), 32'd1);
      check("timeout_cycles", 32'(n_fetch), 32'((2 ** TIMEOUT_W) - 1));
      check("timeout_trap_out", 32'(ifc.o_Trap), 32'd1);
      do_reset();
      #1 check("post_trap_state", 32'(ifc.o_State), 32'd0);
`endif
      run_instr("addi_final", OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALUCTRL_W, default 4, ALU control width; legal values >= 4.
REQ-002 Parameter TIMEOUT_W, default 8, memory-wait timeout counter width.
REQ-003 i_Clk  in  1  clock, all state changes on its rising edge.
REQ-004 i_Reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_OpCode  in  7, i_funct3  in  3, i_funct7_5  in  1: instruction fields.
REQ-006 i_Zero, i_Lt, i_Ltu  in  1 each: ALU flags (equal, signed less-than, unsigned less-than).
REQ-007 i_MemReady  in  1  memory accepts/returns data in the current cycle.
REQ-008 o_MemReq  out  1  memory access request.
REQ-009 o_PCWrite, o_IRWrite, o_MemWrite, o_RegWrite, o_AdrSrc  out  1 each.
REQ-010 o_ResultSrc, o_ALUSrcA, o_ALUSrcB  out  2 each; o_ImmSrc  out  3 (0 I, 1 S, 2 B, 3 J, 4 U).
REQ-011 o_ALUControl  out  ALUCTRL_W; o_State  out  4; o_InstrDone  out  1; o_Trap  out  1.

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP; o_State SHALL carry the encoding 0..14 in that order.
REQ-013 FETCH: o_MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU ADD, ResultSrc=10; o_IRWrite and o_PCWrite SHALL pulse only in the cycle i_MemReady=1, then go to DECODE; otherwise FETCH holds.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ADD; next state by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, other illegal (REQ-030/031).
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ADD; load to MEMREAD, store to MEMWRITE.
REQ-016 MEMREAD: o_MemReq=1, AdrSrc=1; to MEMWB when i_MemReady=1. MEMWB: ResultSrc=01, RegWrite=1, to FETCH.
REQ-017 MEMWRITE: o_MemReq=1, AdrSrc=1, o_MemWrite=1 only while i_MemReady=0 or in the accepting cycle; to FETCH when i_MemReady=1.
REQ-018 EXECR/EXECI: ALUSrcA=10, ALUSrcB=00/01; to ALUWB. ALUWB: ResultSrc=00, RegWrite=1, to FETCH.
REQ-019 ALU encoding (zero-extended to ALUCTRL_W): ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9; SUB only for R-type funct7_5=1 funct3=000; SRA when funct7_5=1 funct3=101 (R and I).
REQ-020 BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00; o_PCWrite=1 when taken: BEQ Zero, BNE !Zero, BLT Lt, BGE !Lt, BLTU Ltu, BGEU !Ltu; funct3 010/011 never taken; to FETCH.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00 with PCWrite=1 from the DECODE target; RegWrite=1 writing old PC+4; to FETCH.
REQ-022 JALR: ALUSrcA=10, ALUSrcB=01, ADD, PCWrite=1, RegWrite=1 (PC+4); to FETCH.
REQ-023 LUI: ALUSrcA=11 (zero), ALUSrcB=01, ADD, to ALUWB; AUIPC: ALUSrcA=01, ALUSrcB=01, ADD, to ALUWB.
REQ-024 o_ImmSrc SHALL be decoded combinationally from i_OpCode in every state.
REQ-025 o_InstrDone SHALL pulse one cycle on every transition into FETCH from a non-FETCH state.
REQ-026 Latency without wait states: R/I 4 cycles, load 5, store 4, branch 3, JAL/JALR 3, LUI/AUIPC 4.

Reset
REQ-027 While i_Reset_n=0 state SHALL be FETCH and every output SHALL be 0, o_State 0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no further write enables; first cycle after release SHALL assert o_MemReq.

Configuration
REQ-029 Macro CTRL_TRAP_EN SHALL select trap support.
REQ-030 With CTRL_TRAP_EN: illegal opcode, or i_MemReady low for 2^TIMEOUT_W-1 consecutive cycles in FETCH/MEMREAD/MEMWRITE, SHALL enter TRAP; TRAP holds o_Trap=1, all enables 0, until reset.
REQ-031 Without CTRL_TRAP_EN: illegal opcode SHALL return to FETCH with no writes, no timeout counter exists, waits are unbounded, o_Trap=0, TRAP unreachable.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3), ready always 1 -> IRWrite cycle 1, RegWrite cycle 4, ALUControl 1 never asserted.
REQ-033 LW with i_MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, RegWrite once, InstrDone once.
REQ-034 BLT with Lt=1 then Lt=0 -> PCWrite in BRANCH only first time; BGEU Ltu=0 -> taken.
REQ-035 Opcode 0x7F: with CTRL_TRAP_EN o_Trap=1, o_State=14 held; without, next state FETCH, no RegWrite/MemWrite.
REQ-036 CTRL_TRAP_EN, TIMEOUT_W=3, i_MemReady=0 in FETCH -> TRAP after 7 cycles; reset pulse in MEMWRITE -> MemWrite 0 immediately, FETCH after release.
